// File: rtl/program_loader_if.sv
// Host byte stream plus code-memory write bus of the boot loader.
// The master side is the host/datapath, the slave side is program_loader.
interface program_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              code_w_en;
    logic [ADDR_W-1:0] code_addr_in;
    logic [DATA_W-1:0] code_in;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  code_w_en,
        input  code_addr_in,
        input  code_in
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output code_w_en,
        output code_addr_in,
        output code_in
    );
endinterface

// File: rtl/program_loader.sv
// program_loader: fills code memory from a framed host byte image, then asserts run.
// Latency: code write the cycle after a word's last byte; run the cycle after the final write.
// Backpressure: rx_ready depends on state only; rx_valid low stalls in place. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module program_loader #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    program_loader_if.slave bus,
    output logic            run,
    output logic            busy,
    output logic            err
);

    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, D_HI, D_LO, WR, CHK, RUN, ERR
    } state_t;

    typedef struct packed {
        logic rdy;
        logic wen;
        logic busy;
        logic run;
        logic err;
    } flags_t;

    // Output flags are loaded together with the state they belong to.
    function automatic flags_t decode(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            LEN_HI, LEN_LO, D_HI, D_LO, CHK: begin
                f.rdy  = 1'b1;
                f.busy = 1'b1;
            end
            WR: begin
                f.wen  = 1'b1;
                f.busy = 1'b1;
            end
            RUN:     f.run = 1'b1;
            ERR:     f.err = 1'b1;
            default: f = '0;
        endcase
        return f;
    endfunction

    state_t            state;
    flags_t            flg;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] word;
    logic              len_hi;
    logic              xfer;

    assign xfer             = bus.rx_valid & flg.rdy;
    assign bus.rx_ready     = flg.rdy;
    assign bus.code_w_en    = flg.wen;
    assign bus.code_addr_in = addr;
    assign bus.code_in      = word;
    assign busy             = flg.busy;
    assign run              = flg.run;
    assign err              = flg.err;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk) begin
        if (rst || load_req) begin
            csum <= '0;
        end else if (xfer && state != CHK) begin
            csum <= csum ^ bus.rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            flg    <= '0;
            addr   <= '0;
            cnt    <= '0;
            word   <= '0;
            len_hi <= 1'b0;
        end else if (load_req) begin
            // Restart wins over a byte offered in the same cycle.
            state <= LEN_HI;
            flg   <= decode(LEN_HI);
            addr  <= '0;
        end else begin
            case (state)
                LEN_HI: if (xfer) begin
                    if (|bus.rx_data[7:1]) begin
                        state <= ERR;
                        flg   <= decode(ERR);
                    end else begin
                        len_hi <= bus.rx_data[0];
                        state  <= LEN_LO;
                        flg    <= decode(LEN_LO);
                    end
                end
                LEN_LO: if (xfer) begin
                    cnt   <= ADDR_W'({len_hi, bus.rx_data});
                    addr  <= '0;
                    state <= D_HI;
                    flg   <= decode(D_HI);
                end
                D_HI: if (xfer) begin
                    word[DATA_W-1 -: 8] <= bus.rx_data;
                    state               <= D_LO;
                    flg                 <= decode(D_LO);
                end
                D_LO: if (xfer) begin
                    word[7:0] <= bus.rx_data;
                    state     <= WR;
                    flg       <= decode(WR);
                end
                WR: begin
                    if (cnt == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= CHK;
                        flg   <= decode(CHK);
`else
                        state <= RUN;
                        flg   <= decode(RUN);
`endif
                    end else begin
                        cnt   <= cnt - 1'b1;
                        addr  <= addr + 1'b1;
                        state <= D_HI;
                        flg   <= decode(D_HI);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (bus.rx_data == csum) begin
                        state <= RUN;
                        flg   <= decode(RUN);
                    end else begin
                        state <= ERR;
                        flg   <= decode(ERR);
                    end
                end
`endif
                default: begin
                    // IDLE, RUN and ERR hold until load_req or rst.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, short/long frames, length error, mid-frame restart, stalls.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_req = 1'b0;
    logic run, busy, err;

    program_loader_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    program_loader #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .bus      (bus),
        .run      (run),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cyc   = 0;
    logic [8:0]  wa[$];
    logic [15:0] wd[$];
    logic [7:0]  fr[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.code_w_en === 1'b1) begin
            wa.push_back(bus.code_addr_in);
            wd.push_back(bus.code_in);
            wr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; rx_valid is left high for back-to-back bytes.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.rx_ready !== 1'b1) check("rx_ready_timeout", 32'(bus.rx_ready), 1);
        @(negedge clk);
    endtask

    task automatic send_frame(input int max_gap);
        foreach (fr[k]) send_byte(fr[k], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        bus.rx_valid = 1'b0;
    endtask

    task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (fr[k]) x ^= fr[k];
        fr.push_back(x);
`endif
    endtask

    task automatic pulse_load();
        wa.delete();
        wd.delete();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (run !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(run), 1);
    endtask

    int c0;
    int bad;

    initial begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5A;

        // Reset with rx_valid high: everything quiet.
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(bus.rx_ready), 0);
        check("rst_run", 32'(run), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_w_en", 32'(bus.code_w_en), 0);
        check("rst_addr", 32'(bus.code_addr_in), 0);
        check("rst_data", 32'(bus.code_in), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_rx_ready", 32'(bus.rx_ready), 0);
        check("idle_busy", 32'(busy), 0);
        bus.rx_valid = 1'b0;

        // One-word frame.
        pulse_load();
        check("t2_busy", 32'(busy), 1);
        check("t2_rx_ready", 32'(bus.rx_ready), 1);
        fr = '{8'h00, 8'h00, 8'hAB, 8'hCD};
`ifdef LOADER_CHECKSUM_EN
        fr.push_back(8'h66);
`endif
        send_frame(0);
        wait_run("t2_run");
`ifndef LOADER_CHECKSUM_EN
        check("t2_run_latency", 32'(cyc - wr_cyc), 1);
`endif
        check("t2_n_writes", 32'(wa.size()), 1);
        if (wa.size() > 0) begin
            check("t2_addr", 32'(wa[0]), 32'h0);
            check("t2_data", 32'(wd[0]), 32'hABCD);
        end
        check("t2_busy_after", 32'(busy), 0);

        // Full 512-word image with rx_valid held high.
        fr = '{8'h01, 8'hFF};
        for (int i = 0; i < 512; i++) begin
            fr.push_back(i[15:8]);
            fr.push_back(i[7:0]);
        end
        add_csum();
        pulse_load();
        c0 = cyc;
        send_frame(0);
        wait_run("t3_run");
`ifdef LOADER_CHECKSUM_EN
        check("t3_cycles", 32'(cyc - c0), 2 + 3 * 512 + 1);
`else
        check("t3_cycles", 32'(cyc - c0), 2 + 3 * 512);
`endif
        check("t3_n_writes", 32'(wa.size()), 512);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== 9'(i) || wd[i] !== 16'(i)) bad++;
        check("t3_order_data", 32'(bad), 0);

        // Illegal length high byte.
        pulse_load();
        send_byte(8'h02, 0);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("t4_err", 32'(err), 1);
        check("t4_run", 32'(run), 0);
        check("t4_busy", 32'(busy), 0);
        check("t4_rx_ready", 32'(bus.rx_ready), 0);
        check("t4_no_write", 32'(wa.size()), 0);
        pulse_load();
        check("t4_err_cleared", 32'(err), 0);
        fr = '{8'h00, 8'h00, 8'h12, 8'h34};
        add_csum();
        send_frame(0);
        wait_run("t4_run_ok");
        check("t4_err_after", 32'(err), 0);
        check("t4_data", (wd.size() > 0) ? 32'(wd[0]) : 32'hDEAD, 32'h1234);

        // Restart mid-frame with a byte offered in the same cycle.
        pulse_load();
        fr = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC};
        send_frame(0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        load_req     = 1'b1;
        @(negedge clk);
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        check("t5_restart_busy", 32'(busy), 1);
        check("t5_restart_rdy", 32'(bus.rx_ready), 1);
        @(negedge clk);
        check("t5_byte_dropped", 32'(wa.size()), 1);
        fr = '{8'h00, 8'h00, 8'h56, 8'h78};
        add_csum();
        send_frame(0);
        wait_run("t5_run");
        check("t5_n_writes", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            check("t5_first", 32'({wa[0], wd[0]}), 32'({9'd0, 16'hAABB}));
            check("t5_second", 32'({wa[1], wd[1]}), 32'({9'd0, 16'h5678}));
        end

        // Random rx_valid gaps.
        pulse_load();
        fr = '{8'h00, 8'h01, 8'h11, 8'h11, 8'h22, 8'h22};
        add_csum();
        send_frame(3);
        wait_run("t6_run");
        check("t6_n_writes", 32'(wa.size()), 2);
        if (wa.size() == 2) begin
            check("t6_w0", 32'({wa[0], wd[0]}), 32'({9'd0, 16'h1111}));
            check("t6_w1", 32'({wa[1], wd[1]}), 32'({9'd1, 16'h2222}));
        end

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word lands in memory but the core stays halted.
        pulse_load();
        fr = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h00};
        send_frame(0);
        repeat (2) @(negedge clk);
        check("t6_csum_err", 32'(err), 1);
        check("t6_csum_run", 32'(run), 0);
        check("t6_csum_written", 32'(wa.size()), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
